// File: rtl/dmem_access_unit_if.sv
// Request/response bundle between the MEM stage and the data-memory access unit.
// The master drives the request; the slave (access unit) answers with a one-cycle response.
interface dmem_access_unit_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [2:0]      req_func3;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_func3, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_func3, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: byte-enabled sync RAM, load/store formatting, two-beat misaligned.
// Optional DMEM_MISALIGN_TRAP_EN: word-crossing accesses answer with resp_err instead.
module dmem_access_unit #(
    parameter int    XLEN       = 64,
    parameter int    DEPTH_LOG2 = 13,
    parameter string INIT_FILE  = ""
) (
    input logic          clk,
    input logic          rst,
    dmem_access_unit_if.slave bus
);
    localparam int WB    = XLEN / 8;
    localparam int OFFW  = $clog2(WB);
    localparam int AW    = DEPTH_LOG2;
    localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef DMEM_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, DONE} state_e;
`else
    typedef enum logic [1:0] {IDLE, BEAT1, DONE} state_e;
`endif

    function automatic logic [2*WB-1:0] mask_of(input logic [OFFW-1:0] off,
                                                input logic [1:0] f);
        logic [2*WB-1:0] m;
        case (f)
            2'b00:   m = (2*WB)'(8'h01);
            2'b01:   m = (2*WB)'(8'h03);
            2'b10:   m = (2*WB)'(8'h0F);
            default: m = (2*WB)'(8'hFF);
        endcase
        return m << off;
    endfunction

    function automatic logic [2*XLEN-1:0] place(input logic [XLEN-1:0] d,
                                                input logic [OFFW-1:0] off);
        return {{XLEN{1'b0}}, d} << {off, 3'b000};
    endfunction

    function automatic logic is_split(input logic [OFFW-1:0] off, input logic [1:0] f);
        return (int'(off) + (1 << f)) > WB;
    endfunction

    function automatic logic is_illegal(input logic we, input logic [2:0] f);
        logic ill;
        ill = (f == 3'b111) || (we && f[2]);
        if (XLEN == 32)
            ill = ill || (f[1:0] == 2'b11) || (f == 3'b110);
        return ill;
    endfunction

    state_e          state_q;
    logic [AW-1:0]   word_q;
    logic [OFFW-1:0] off_q;
    logic [2:0]      func3_q;
    logic [XLEN-1:0] wdata_q;
    logic            we_q;
    logic            err_q;
`ifndef DMEM_MISALIGN_TRAP_EN
    logic            split_q;
    logic [XLEN-1:0] hold_q;
`endif

    logic [AW-1:0]   req_word;
    logic [OFFW-1:0] req_off;
    logic            req_split;
    logic            req_ill;
    logic            accept;

    assign req_word  = bus.req_addr[AW+OFFW-1:OFFW];
    assign req_off   = bus.req_addr[OFFW-1:0];
    assign req_split = is_split(req_off, bus.req_func3[1:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
    assign req_ill   = is_illegal(bus.req_we, bus.req_func3) || req_split;
`else
    assign req_ill   = is_illegal(bus.req_we, bus.req_func3);
`endif
    assign accept    = bus.req_valid && (state_q == IDLE);

    // Single RAM port: beat0 straight from the request, beat1 from captured state.
    logic [AW-1:0]   ram_addr;
    logic            ram_we;
    logic [WB-1:0]   ram_be;
    logic [XLEN-1:0] ram_wd;
    logic [XLEN-1:0] ram_rd_q;
    logic [2*WB-1:0]   mask_w;
    logic [2*XLEN-1:0] data_w;

    always_comb begin
        ram_addr = req_word;
        ram_we   = 1'b0;
        mask_w   = mask_of(req_off, bus.req_func3[1:0]);
        data_w   = place(bus.req_wdata, req_off);
        ram_be   = mask_w[WB-1:0];
        ram_wd   = data_w[XLEN-1:0];
        if (state_q == IDLE) begin
            ram_we = accept && bus.req_we && !req_ill;
        end
`ifndef DMEM_MISALIGN_TRAP_EN
        else if (state_q == BEAT1) begin
            mask_w   = mask_of(off_q, func3_q[1:0]);
            data_w   = place(wdata_q, off_q);
            ram_addr = word_q + 1'b1;
            ram_we   = we_q;
            ram_be   = mask_w[2*WB-1:WB];
            ram_wd   = data_w[2*XLEN-1:XLEN];
        end
`endif
        if (rst)
            ram_we = 1'b0;
    end

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < WB; b++)
                if (ram_be[b])
                    mem[ram_addr][b*8 +: 8] <= ram_wd[b*8 +: 8];
        end
        ram_rd_q <= mem[ram_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            off_q   <= '0;
            func3_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
`ifndef DMEM_MISALIGN_TRAP_EN
            split_q <= 1'b0;
            hold_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        word_q  <= req_word;
                        off_q   <= req_off;
                        func3_q <= bus.req_func3;
                        wdata_q <= bus.req_wdata;
                        we_q    <= bus.req_we;
                        err_q   <= req_ill;
`ifndef DMEM_MISALIGN_TRAP_EN
                        split_q <= req_split && !req_ill;
                        state_q <= (req_split && !req_ill) ? BEAT1 : DONE;
`else
                        state_q <= DONE;
`endif
                    end
                end
`ifndef DMEM_MISALIGN_TRAP_EN
                BEAT1: begin
                    hold_q  <= ram_rd_q;
                    state_q <= DONE;
                end
`endif
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [XLEN-1:0]   lo_word;
    logic [2*XLEN-1:0] win;
    logic [XLEN-1:0]   ld_sh;
    logic [XLEN-1:0]   msk;
    logic              sgn;
    logic [XLEN-1:0]   ld_val;

`ifndef DMEM_MISALIGN_TRAP_EN
    assign lo_word = split_q ? hold_q : ram_rd_q;
`else
    assign lo_word = ram_rd_q;
`endif

    always_comb begin
        win   = {ram_rd_q, lo_word};
        ld_sh = XLEN'(win >> {off_q, 3'b000});
        msk   = '1;
        sgn   = 1'b0;
        case (func3_q[1:0])
            2'b00: begin msk = XLEN'(8'hFF);         sgn = ld_sh[7];  end
            2'b01: begin msk = XLEN'(16'hFFFF);      sgn = ld_sh[15]; end
            2'b10: begin msk = XLEN'(32'hFFFF_FFFF); sgn = ld_sh[31]; end
            default: begin msk = '1; sgn = 1'b0; end
        endcase
        ld_val = ld_sh & msk;
        if (!func3_q[2] && sgn)
            ld_val = ld_val | ~msk;
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == DONE);
    assign bus.resp_err   = (state_q == DONE) && err_q;
    assign bus.resp_rdata = ((state_q == DONE) && !err_q && !we_q) ? ld_val : '0;
endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed-vector bench for dmem_access_unit at XLEN=64, DEPTH_LOG2=13.
// Each request checks ready, response latency, rdata, err and the single-cycle pulse.
module tb_dmem_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    dmem_access_unit_if #(.XLEN(64)) bus ();

    dmem_access_unit #(.XLEN(64), .DEPTH_LOG2(13), .INIT_FILE("")) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic req(input string tag, input logic we, input logic [63:0] addr,
                       input logic [2:0] f3, input logic [63:0] wd, input int lat,
                       input logic [63:0] exp_rd, input logic exp_err);
        int n;
        @(negedge clk);
        check({tag, ".ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_func3 = f3;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = {$urandom, $urandom};
        bus.req_wdata = {$urandom, $urandom};
        bus.req_func3 = 3'($urandom);
        bus.req_we    = 1'($urandom);
        n = 1;
        while (bus.resp_valid !== 1'b1 && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".lat"}, 64'(n), 64'(lat));
        check({tag, ".rdata"}, bus.resp_rdata, exp_rd);
        check({tag, ".err"}, 64'(bus.resp_err), 64'(exp_err));
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, 64'(bus.resp_valid), 64'd0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_func3 = '0;
        bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", 64'(bus.req_ready), 64'd1);
        check("rst.valid", 64'(bus.resp_valid), 64'd0);
        check("rst.rdata", bus.resp_rdata, 64'd0);
        check("rst.err", 64'(bus.resp_err), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        req("sd100", 1, 64'h100, 3'b011, 64'h1122334455667788, 1, 64'd0, 0);
        req("ld100", 0, 64'h100, 3'b011, 64'd0, 1, 64'h1122334455667788, 0);
        req("lb107", 0, 64'h107, 3'b000, 64'd0, 1, 64'h11, 0);
        req("sb107", 1, 64'h107, 3'b000, 64'h80, 1, 64'd0, 0);
        req("lb107s", 0, 64'h107, 3'b000, 64'd0, 1, 64'hFFFFFFFFFFFFFF80, 0);
        req("lbu107", 0, 64'h107, 3'b100, 64'd0, 1, 64'h80, 0);
        req("lh106", 0, 64'h106, 3'b001, 64'd0, 1, 64'hFFFFFFFFFFFF8022, 0);

        req("sd108z", 1, 64'h108, 3'b011, 64'd0, 1, 64'd0, 0);
        req("sd110z", 1, 64'h110, 3'b011, 64'd0, 1, 64'd0, 0);
        req("sw106", 1, 64'h106, 3'b010, 64'hAABBCCDD, 2, 64'd0, 0);
        req("lw106", 0, 64'h106, 3'b010, 64'd0, 2, 64'hFFFFFFFFAABBCCDD, 0);
        req("lwu106", 0, 64'h106, 3'b110, 64'd0, 2, 64'h00000000AABBCCDD, 0);
        req("ld100b", 0, 64'h100, 3'b011, 64'd0, 1, 64'hCCDD334455667788, 0);
        req("ld108", 0, 64'h108, 3'b011, 64'd0, 1, 64'h000000000000AABB, 0);

        req("shwrap", 1, 64'hFFFF, 3'b001, 64'hBEEF, 2, 64'd0, 0);
        req("lhuwrap", 0, 64'hFFFF, 3'b101, 64'd0, 2, 64'hBEEF, 0);
        req("lbulast", 0, 64'hFFFF, 3'b100, 64'd0, 1, 64'hEF, 0);
        req("lbuw0", 0, 64'h0, 3'b100, 64'd0, 1, 64'hBE, 0);
        req("lbmod", 0, 64'h10000, 3'b000, 64'd0, 1, 64'hFFFFFFFFFFFFFFBE, 0);

        req("sd200", 1, 64'h200, 3'b011, 64'h0123456789ABCDEF, 1, 64'd0, 0);
        req("st111", 1, 64'h200, 3'b111, 64'hFFFFFFFFFFFFFFFF, 1, 64'd0, 1);
        req("st100", 1, 64'h200, 3'b100, 64'hFFFFFFFFFFFFFFFF, 1, 64'd0, 1);
        req("ld111", 0, 64'h200, 3'b111, 64'd0, 1, 64'd0, 1);
        req("ld200", 0, 64'h200, 3'b011, 64'd0, 1, 64'h0123456789ABCDEF, 0);

        req("sd108c", 1, 64'h108, 3'b011, 64'd0, 1, 64'd0, 0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 64'h10C;
        bus.req_func3 = 3'b011;
        bus.req_wdata = 64'hDEADBEEFCAFEF00D;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("rstmid.beat1", 64'(bus.req_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstmid.ready", 64'(bus.req_ready), 64'd1);
        check("rstmid.valid", 64'(bus.resp_valid), 64'd0);
        @(posedge clk);
        #1;
        check("rstmid.valid2", 64'(bus.resp_valid), 64'd0);
        req("ld108r", 0, 64'h108, 3'b011, 64'd0, 1, 64'hCAFEF00D00000000, 0);
        req("ld110r", 0, 64'h110, 3'b011, 64'd0, 1, 64'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
